// File: rtl/ofs_plat_utils_ccip_c1_packet_gate.sv
// ofs_plat_utils_ccip_c1_packet_gate
//   Store-and-forward gate for the CCI-P c1 Tx (write request) channel. Every
//   beat is buffered and a packet is presented downstream only once its EOP
//   beat is stored, so multi-line writes leave contiguously with no bubbles.
//
// Ports
//   clk, reset_n   clock, synchronous active-low reset
//   c1Tx_in        AFU request, consumed whenever .valid=1
//   c1TxAlmFull    registered almost-full back-pressure to the AFU
//   c1Tx_out       head beat, .valid only when its packet is fully buffered
//   c1Tx_out_deq   downstream consumed the head beat
//   c1Tx_out_eop   head beat is the last beat of its packet
//   overflow_err   sticky, a beat arrived while storage was full
//
// Optional build macro
//   OFS_PLAT_CCIP_C1_PACKET_GATE_OUT_REG_EN  drive outputs from a prefetched
//   1-entry output register (one extra cycle of latency, full streaming rate).

package ofs_plat_utils_ccip_c1_packet_gate_pkg;

    typedef logic [1:0]   t_ccip_clLen;
    typedef logic [1:0]   t_ccip_clNum;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic         sop;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    // One buffered beat: the message plus its end-of-packet flag
    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               eop;
    } t_c1_gate_entry;

    // Only line writes span multiple beats; fences and interrupts are single-beat
    function automatic logic is_write(input t_ccip_c1_req req);
        case (req)
            eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I: is_write = 1'b1;
            default:                                     is_write = 1'b0;
        endcase
    endfunction

endpackage

module ofs_plat_utils_ccip_c1_packet_gate
    import ofs_plat_utils_ccip_c1_packet_gate_pkg::*;
#(
    parameter int unsigned N_ENTRIES          = 16,
    parameter int unsigned ALMFULL_THRESHOLD  = 4,
    // Clear to make an overflow non-fatal in simulation (the sticky flag still latches)
    parameter bit          SIM_OVERFLOW_FATAL = 1'b1
)(
    input  logic           clk,
    input  logic           reset_n,
    input  t_if_ccip_c1_Tx c1Tx_in,
    output logic           c1TxAlmFull,
    output t_if_ccip_c1_Tx c1Tx_out,
    input  logic           c1Tx_out_deq,
    output logic           c1Tx_out_eop,
    output logic           overflow_err
);

    localparam int unsigned AW = $clog2(N_ENTRIES);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0] t_ptr;

    t_c1_gate_entry mem [N_ENTRIES];
    t_ptr           wr_ptr, rd_ptr, cpl_cnt;
    t_ccip_clNum    in_beat;

    logic           empty_c, full_c, in_is_wr_c, in_eop_c;
    logic           push_c, pop_c, pop_eop_c, buf_avail_c;
    logic           out_valid_c, almfull_nxt_c;
    t_c1_gate_entry head_c, in_entry_c, out_entry_c;
    t_ptr           wr_ptr_nxt_c, rd_ptr_nxt_c, used_nxt_c;

    // Pointer MSB distinguishes full from empty when the index bits match
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_is_wr_c = is_write(c1Tx_in.hdr.req_type);
    assign in_eop_c   = !in_is_wr_c || (in_beat == t_ccip_clNum'(c1Tx_in.hdr.cl_len));
    assign push_c     = c1Tx_in.valid && !full_c;

    assign in_entry_c = '{hdr: c1Tx_in.hdr, data: c1Tx_in.data, eop: in_eop_c};
    assign head_c     = mem[rd_ptr[AW-1:0]];

    // A non-zero complete count means the head packet's beats are all present
    assign buf_avail_c = !empty_c && (cpl_cnt != '0);

`ifdef OFS_PLAT_CCIP_C1_PACKET_GATE_OUT_REG_EN
    t_c1_gate_entry oreg;
    logic           oreg_valid;

    // Refill whenever the register is empty or being drained this cycle
    assign pop_c       = buf_avail_c && (!oreg_valid || c1Tx_out_deq);
    assign out_valid_c = oreg_valid;
    assign out_entry_c = oreg;

    // Prefetched output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            oreg_valid <= 1'b0;
            oreg       <= '0;
        end else if (pop_c) begin
            oreg_valid <= 1'b1;
            oreg       <= head_c;
        end else if (c1Tx_out_deq) begin
            oreg_valid <= 1'b0;
        end
    end
`else
    assign pop_c       = c1Tx_out_deq && buf_avail_c;
    assign out_valid_c = buf_avail_c;
    assign out_entry_c = head_c;
`endif

    assign pop_eop_c = pop_c && head_c.eop;

    // Occupancy after this cycle's push and pop feeds the registered almost-full
    assign wr_ptr_nxt_c  = wr_ptr + t_ptr'(push_c);
    assign rd_ptr_nxt_c  = rd_ptr + t_ptr'(pop_c);
    assign used_nxt_c    = wr_ptr_nxt_c - rd_ptr_nxt_c;
    assign almfull_nxt_c = (32'(N_ENTRIES) - 32'(used_nxt_c)) <= 32'(ALMFULL_THRESHOLD);

    // Outputs are zero whenever nothing is presented
    always_comb begin
        c1Tx_out     = '0;
        c1Tx_out_eop = 1'b0;
        if (out_valid_c) begin
            c1Tx_out.hdr   = out_entry_c.hdr;
            c1Tx_out.data  = out_entry_c.data;
            c1Tx_out.valid = 1'b1;
            c1Tx_out_eop   = out_entry_c.eop;
        end
    end

    // Beat storage
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= in_entry_c;
        end
    end

    // Pointers, beat tracking, packet count and status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cpl_cnt      <= '0;
            in_beat      <= '0;
            c1TxAlmFull  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt_c;
            rd_ptr      <= rd_ptr_nxt_c;
            c1TxAlmFull <= almfull_nxt_c;

            // Dropped beats still advance the counter so later packets stay aligned
            if (c1Tx_in.valid && in_is_wr_c) begin
                in_beat <= in_eop_c ? '0 : t_ccip_clNum'(in_beat + 2'd1);
            end

            case ({push_c && in_eop_c, pop_eop_c})
                2'b10:   cpl_cnt <= cpl_cnt + t_ptr'(1);
                2'b01:   cpl_cnt <= cpl_cnt - t_ptr'(1);
                default: cpl_cnt <= cpl_cnt;
            endcase

            if (c1Tx_in.valid && full_c) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    t_ccip_clLen pkt_cl_len;

    // Length of the write packet in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pkt_cl_len <= '0;
        end else if (c1Tx_in.valid && in_is_wr_c && (in_beat == '0)) begin
            pkt_cl_len <= c1Tx_in.hdr.cl_len;
        end
    end

    // Protocol checks
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (c1Tx_in.valid && in_is_wr_c) begin
                if (c1Tx_in.hdr.sop != (in_beat == '0))
                    $fatal(1, "c1 packet gate: sop does not match beat position");
                if ((in_beat != '0) && (c1Tx_in.hdr.cl_len != pkt_cl_len))
                    $fatal(1, "c1 packet gate: cl_len changed within a packet");
            end
            if (SIM_OVERFLOW_FATAL && c1Tx_in.valid && full_c)
                $fatal(1, "c1 packet gate: beat arrived while storage full");
            if (c1Tx_out_deq && !out_valid_c)
                $fatal(1, "c1 packet gate: dequeue while output not valid");
        end
    end
`endif

endmodule

// File: tb/tb_ofs_plat_utils_ccip_c1_packet_gate.sv
// Bench for ofs_plat_utils_ccip_c1_packet_gate (default build, FWFT outputs).
// Directed packets push expected beats into a queue; a negedge monitor pops
// and compares every beat the DUT hands downstream.

module tb_ofs_plat_utils_ccip_c1_packet_gate;
    import ofs_plat_utils_ccip_c1_packet_gate_pkg::*;

    logic           clk = 1'b0;
    logic           reset_n;
    t_if_ccip_c1_Tx c1Tx_in;
    t_if_ccip_c1_Tx c1Tx_out;
    logic           c1TxAlmFull, c1Tx_out_deq, c1Tx_out_eop, overflow_err;
    logic           dq_en;

    typedef struct {
        logic [15:0]  mdata;
        t_ccip_clData data;
        logic         eop;
    } t_exp;

    t_exp exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Downstream consumes whenever enabled and something is presented
    assign c1Tx_out_deq = dq_en && c1Tx_out.valid;

    ofs_plat_utils_ccip_c1_packet_gate #(
        .N_ENTRIES          (16),
        .ALMFULL_THRESHOLD  (4),
        .SIM_OVERFLOW_FATAL (1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .c1Tx_in      (c1Tx_in),
        .c1TxAlmFull  (c1TxAlmFull),
        .c1Tx_out     (c1Tx_out),
        .c1Tx_out_deq (c1Tx_out_deq),
        .c1Tx_out_eop (c1Tx_out_eop),
        .overflow_err (overflow_err)
    );

    function automatic t_ccip_clData mk_data(input logic [15:0] md);
        mk_data = {16{md, 16'hA5C3}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every beat taken downstream must match the queue head
    always @(negedge clk) begin
        if (reset_n && c1Tx_out.valid && c1Tx_out_deq) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_beat: unexpected beat mdata=%0h", c1Tx_out.hdr.mdata);
            end else begin
                t_exp e;
                e = exp_q.pop_front();
                if (c1Tx_out.hdr.mdata !== e.mdata || c1Tx_out.data !== e.data ||
                    c1Tx_out_eop !== e.eop) begin
                    n_err++;
                    $display("FAIL out_beat: got mdata=%0h data[31:0]=%0h eop=%0b expected mdata=%0h data[31:0]=%0h eop=%0b",
                             c1Tx_out.hdr.mdata, c1Tx_out.data[31:0], c1Tx_out_eop,
                             e.mdata, e.data[31:0], e.eop);
                end
            end
        end
    end

    // Drive one beat for one cycle; called at posedge+1, returns at posedge+1
    task automatic send(input t_ccip_c1_req rt, input t_ccip_clLen len, input logic sop,
                        input logic [15:0] md, input logic exp_out, input logic exp_eop);
        t_exp e;
        c1Tx_in.valid        = 1'b1;
        c1Tx_in.hdr.req_type = rt;
        c1Tx_in.hdr.cl_len   = len;
        c1Tx_in.hdr.sop      = sop;
        c1Tx_in.hdr.mdata    = md;
        c1Tx_in.hdr.address  = 42'(md);
        c1Tx_in.data         = mk_data(md);
        if (exp_out) begin
            e.mdata = md;
            e.data  = mk_data(md);
            e.eop   = exp_eop;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        c1Tx_in.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   64'(c1Tx_out.valid), 64'd0);
        check({tag, "_almfull"}, 64'(c1TxAlmFull),    64'd0);
        check({tag, "_eop"},     64'(c1Tx_out_eop),   64'd0);
        check({tag, "_ovf"},     64'(overflow_err),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        c1Tx_in = '0;
        dq_en   = 1'b0;
        idle(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        idle(1);

        // Single-line write, then a fence: each valid with eop the next cycle
        dq_en = 1'b1;
        send(eREQ_WRLINE_I, 2'd0, 1'b1, 16'h0001, 1'b1, 1'b1);
        @(negedge clk);
        check("single_valid", 64'(c1Tx_out.valid), 64'd1);
        check("single_eop",   64'(c1Tx_out_eop),   64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_empty", 64'(c1Tx_out.valid), 64'd0);
        @(posedge clk); #1;
        send(eREQ_WRFENCE, 2'd0, 1'b0, 16'h0002, 1'b1, 1'b1);
        @(negedge clk);
        check("fence_valid", 64'(c1Tx_out.valid), 64'd1);
        check("fence_eop",   64'(c1Tx_out_eop),   64'd1);
        @(posedge clk); #1;

        // 4-line write with gaps: nothing until EOP, then 4 contiguous beats
        for (int b = 0; b < 4; b++) begin
            send(eREQ_WRLINE_M, 2'd3, (b == 0), 16'h0010 + 16'(b), 1'b1, (b == 3));
            if (b < 3) begin
                @(negedge clk);
                check("ml4_hold", 64'(c1Tx_out.valid), 64'd0);
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ml4_stream_valid", 64'(c1Tx_out.valid), 64'd1);
            check("ml4_stream_eop",   64'(c1Tx_out_eop),   64'(k == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("ml4_after", 64'(c1Tx_out.valid), 64'd0);
        @(posedge clk); #1;

        // 2-line packet completes, 4-line packet half sent: only 2 beats leave
        send(eREQ_WRLINE_I, 2'd1, 1'b1, 16'h0020, 1'b1, 1'b0);
        send(eREQ_WRLINE_I, 2'd1, 1'b0, 16'h0021, 1'b1, 1'b1);
        send(eREQ_WRLINE_I, 2'd3, 1'b1, 16'h0030, 1'b1, 1'b0);
        send(eREQ_WRLINE_I, 2'd3, 1'b0, 16'h0031, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("partial_hold", 64'(c1Tx_out.valid), 64'd0);
            @(posedge clk); #1;
        end
        check("partial_pending", 64'(exp_q.size()), 64'd2);
        send(eREQ_WRLINE_I, 2'd3, 1'b0, 16'h0032, 1'b1, 1'b0);
        send(eREQ_WRLINE_I, 2'd3, 1'b0, 16'h0033, 1'b1, 1'b1);
        wait_drain("partial_drain");

        // EOP write and EOP dequeue in the same cycle keep the packet count at 1
        dq_en = 1'b0;
        idle(1);
        send(eREQ_WRLINE_I, 2'd0, 1'b1, 16'h0040, 1'b1, 1'b1);
        @(negedge clk);
        check("same_cyc_pre", 64'(c1Tx_out.valid), 64'd1);
        @(posedge clk); #1;
        dq_en = 1'b1;
        send(eREQ_WRLINE_I, 2'd0, 1'b1, 16'h0041, 1'b1, 1'b1);
        @(negedge clk);
        check("same_cyc_valid", 64'(c1Tx_out.valid), 64'd1);
        check("same_cyc_eop",   64'(c1Tx_out_eop),   64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("same_cyc_empty", 64'(c1Tx_out.valid), 64'd0);
        @(posedge clk); #1;

        // Fill to almost-full and past full; the 17th beat is dropped
        dq_en = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            send(eREQ_WRLINE_I, 2'd0, 1'b1, 16'h0100 + 16'(i), (i <= 16), 1'b1);
            check("fill_almfull", 64'(c1TxAlmFull),  64'(i >= 12));
            check("fill_ovf",     64'(overflow_err), 64'(i == 17));
        end
        dq_en = 1'b1;
        wait_drain("fill_drain");
        idle(2);
        check("fill_after_valid",   64'(c1Tx_out.valid), 64'd0);
        check("fill_after_almfull", 64'(c1TxAlmFull),    64'd0);
        check("fill_after_ovf",     64'(overflow_err),   64'd1);

        // Reset mid-packet clears everything; a fresh packet restarts at beat 0
        send(eREQ_WRLINE_I, 2'd3, 1'b1, 16'h0050, 1'b0, 1'b0);
        send(eREQ_WRLINE_I, 2'd3, 1'b0, 16'h0051, 1'b0, 1'b0);
        reset_n = 1'b0;
        idle(2);
        check_all_zero("midrst");
        reset_n = 1'b1;
        idle(1);
        send(eREQ_WRLINE_I, 2'd0, 1'b1, 16'h0060, 1'b1, 1'b1);
        @(negedge clk);
        check("post_rst_valid", 64'(c1Tx_out.valid), 64'd1);
        check("post_rst_eop",   64'(c1Tx_out_eop),   64'd1);
        @(posedge clk); #1;
        wait_drain("final_drain");
        idle(2);
        check("final_valid", 64'(c1Tx_out.valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
